// File: rtl/i2c_txn_frontend.sv
// ---------------------------------------------------------------------------
// i2c_txn_frontend
//
// Purpose:
//   Command stage in front of the I2C controller FSM/datapath. It takes one
//   transaction per request, launches the controller, gathers received bytes,
//   watches for NACK and a watchdog timeout, and returns one response per
//   request.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   req_valid/ready    request handshake (req_ready is the only comb output)
//   req_addr/rw/wdata  7-bit target address, direction, up to 3 write bytes
//   resp_valid/ready   response handshake
//   resp_rdata         received bytes, first byte in [7:0]
//   resp_status        0 = OK, 1 = NACK, 2 = TIMEOUT
//   start              launch strobe to the controller
//   addr_rw, rw        latched {addr, rw} and direction for the controller
//   tx_data            latched write bytes for the controller datapath
//   ctrl_idle          controller FSM is in IDLE
//   rx_valid, rx_byte  one-cycle pulse carrying a received byte
//   nack               one-cycle pulse: target did not acknowledge
// ---------------------------------------------------------------------------
module i2c_txn_frontend #(
  parameter int unsigned TIMEOUT_CYCLES = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic        req_rw,
  input  logic [23:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [23:0] resp_rdata,
  output logic [1:0]  resp_status,
  output logic        start,
  output logic [7:0]  addr_rw,
  output logic        rw,
  output logic [23:0] tx_data,
  input  logic        ctrl_idle,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        nack
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

  localparam logic [1:0]  STATUS_OK      = 2'd0;
  localparam logic [1:0]  STATUS_NACK    = 2'd1;
  localparam logic [1:0]  STATUS_TIMEOUT = 2'd2;
  localparam logic [15:0] COUNT_LAST     = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_nextState;

  logic        r_start;
  logic        r_respValid;
  logic [23:0] r_respRdata;
  logic [1:0]  r_respStatus;
  logic [7:0]  r_addrRw;
  logic        r_rw;
  logic [23:0] r_txData;
  logic [1:0]  r_rxIdx;
  logic [15:0] r_count;

  logic [23:0] w_respRdataNext;
  logic [1:0]  w_respStatusNext;
  logic [7:0]  w_addrRwNext;
  logic        w_rwNext;
  logic [23:0] w_txDataNext;
  logic [1:0]  w_rxIdxNext;
  logic [15:0] w_countNext;

  logic        w_accept;
  logic        w_expire;
  logic        w_respTake;

  // A new request is only taken once both this block and the controller are
  // idle, which also holds off new work after a timeout left the bus busy.
  assign req_ready  = (r_state == IDLE) && ctrl_idle;
  assign w_accept   = req_valid && req_ready;
  assign w_expire   = (r_count == COUNT_LAST);
  assign w_respTake = r_respValid && resp_ready;

  assign start       = r_start;
  assign resp_valid  = r_respValid;
  assign resp_rdata  = r_respRdata;
  assign resp_status = r_respStatus;
  assign addr_rw     = r_addrRw;
  assign rw          = r_rw;
  assign tx_data     = r_txData;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // Next-state logic; in RUN a controller return beats a same-cycle expiry
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = LAUNCH;
      LAUNCH:  if (w_expire) w_nextState = RESP;
               else if (!ctrl_idle) w_nextState = RUN;
      RUN:     if (ctrl_idle || w_expire) w_nextState = RESP;
      RESP:    if (w_respTake) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output/datapath next values; TIMEOUT overrides a NACK seen in the same
  // transaction because it is written after the NACK update.
  always_comb begin
    w_respRdataNext  = r_respRdata;
    w_respStatusNext = r_respStatus;
    w_addrRwNext     = r_addrRw;
    w_rwNext         = r_rw;
    w_txDataNext     = r_txData;
    w_rxIdxNext      = r_rxIdx;
    w_countNext      = r_count;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_addrRwNext     = {req_addr, req_rw};
          w_rwNext         = req_rw;
          w_txDataNext     = req_wdata;
          w_respRdataNext  = 24'd0;
          w_respStatusNext = STATUS_OK;
          w_rxIdxNext      = 2'd0;
          w_countNext      = 16'd0;
        end
      end
      LAUNCH: begin
        if (r_count != 16'hFFFF) w_countNext = r_count + 16'd1;
        if (nack) w_respStatusNext = STATUS_NACK;
        if (w_expire) w_respStatusNext = STATUS_TIMEOUT;
      end
      RUN: begin
        if (r_count != 16'hFFFF) w_countNext = r_count + 16'd1;
        if (rx_valid && r_rw && (r_rxIdx != 2'd3)) begin
          case (r_rxIdx)
            2'd0:    w_respRdataNext[7:0]   = rx_byte;
            2'd1:    w_respRdataNext[15:8]  = rx_byte;
            default: w_respRdataNext[23:16] = rx_byte;
          endcase
          w_rxIdxNext = r_rxIdx + 2'd1;
        end
        if (nack) w_respStatusNext = STATUS_NACK;
        if (w_expire && !ctrl_idle) w_respStatusNext = STATUS_TIMEOUT;
      end
      default: ;
    endcase
  end

  // Output registers; start and resp_valid follow the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start      <= 1'b0;
      r_respValid  <= 1'b0;
      r_respRdata  <= 24'd0;
      r_respStatus <= STATUS_OK;
      r_addrRw     <= 8'd0;
      r_rw         <= 1'b0;
      r_txData     <= 24'd0;
      r_rxIdx      <= 2'd0;
      r_count      <= 16'd0;
    end else begin
      r_start      <= (w_nextState == LAUNCH);
      r_respValid  <= (w_nextState == RESP);
      r_respRdata  <= w_respRdataNext;
      r_respStatus <= w_respStatusNext;
      r_addrRw     <= w_addrRwNext;
      r_rw         <= w_rwNext;
      r_txData     <= w_txDataNext;
      r_rxIdx      <= w_rxIdxNext;
      r_count      <= w_countNext;
    end
  end

endmodule
